// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - CPU request responder bridging 8/16/32/48-bit accesses onto a 16-bit sync SRAM
module cpu_mem_responder (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        cpu_enable,
   output logic [47:0] cpu_data_in,
   output logic        req_err,
   output logic [30:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [1:0]  mem_byte_en,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ISSUE,
      S_RD_CAPTURE,
      S_WR_BEAT,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic        byte_sel_q, byte_sel_d;
   logic [30:0] hw_addr_q, hw_addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  beat_q, beat_d;
   logic [47:0] rd_buf_q, rd_buf_d;
   logic [47:0] cpu_data_q, cpu_data_d;
   logic        req_err_q, req_err_d;

   logic [1:0]  last_beat_idx;
   logic        last_beat;
   logic        reject;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         size_q     <= 2'd0;
         byte_sel_q <= 1'b0;
         hw_addr_q  <= 31'd0;
         wdata_q    <= 32'd0;
         beat_q     <= 2'd0;
         rd_buf_q   <= 48'd0;
         cpu_data_q <= 48'd0;
         req_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         byte_sel_q <= byte_sel_d;
         hw_addr_q  <= hw_addr_d;
         wdata_q    <= wdata_d;
         beat_q     <= beat_d;
         rd_buf_q   <= rd_buf_d;
         cpu_data_q <= cpu_data_d;
         req_err_q  <= req_err_d;
      end
   end

   always_comb begin
      case (size_q)
         2'd3:    last_beat_idx = 2'd2;
         2'd2:    last_beat_idx = 2'd1;
         default: last_beat_idx = 2'd0;
      endcase
      last_beat = (beat_q == last_beat_idx);
      reject    = (req_rd & req_wr)
                | ((req_size != 2'd0) & req_addr[0])
                | (req_wr & (req_size == 2'd3));
   end

   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      byte_sel_d = byte_sel_q;
      hw_addr_d  = hw_addr_q;
      wdata_d    = wdata_q;
      beat_d     = beat_q;
      rd_buf_d   = rd_buf_q;
      cpu_data_d = cpu_data_q;
      req_err_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_rd | req_wr) begin
               if (reject) begin
                  req_err_d  = 1'b1;
                  cpu_data_d = 48'd0;
               end else begin
                  size_d     = req_size;
                  byte_sel_d = req_addr[0];
                  hw_addr_d  = req_addr[31:1];
                  wdata_d    = req_wdata;
                  beat_d     = 2'd0;
                  rd_buf_d   = 48'd0;
                  state_d    = req_rd ? S_RD_ISSUE : S_WR_BEAT;
               end
            end
         end
         S_RD_ISSUE: begin
            state_d = S_RD_CAPTURE;
         end
         S_RD_CAPTURE: begin
            // Byte reads return only the addressed lane, zero-extended.
            if (size_q == 2'd0) begin
               rd_buf_d = {40'd0, byte_sel_q ? mem_rdata[15:8] : mem_rdata[7:0]};
            end else begin
               case (beat_q)
                  2'd0:    rd_buf_d[15:0]  = mem_rdata;
                  2'd1:    rd_buf_d[31:16] = mem_rdata;
                  default: rd_buf_d[47:32] = mem_rdata;
               endcase
            end
            if (last_beat) begin
               cpu_data_d = rd_buf_d;
               state_d    = S_DONE;
            end else begin
               beat_d    = beat_q + 2'd1;
               hw_addr_d = hw_addr_q + 31'd1;
               state_d   = S_RD_ISSUE;
            end
         end
         S_WR_BEAT: begin
            if (last_beat) begin
               state_d = S_DONE;
            end else begin
               beat_d    = beat_q + 2'd1;
               hw_addr_d = hw_addr_q + 31'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      mem_rd      = (state_q == S_RD_ISSUE);
      mem_wr      = (state_q == S_WR_BEAT);
      mem_addr    = 31'd0;
      mem_byte_en = 2'b00;
      mem_wdata   = 16'd0;
      if (mem_rd) begin
         mem_addr    = hw_addr_q;
         mem_byte_en = 2'b11;
      end
      if (mem_wr) begin
         mem_addr = hw_addr_q;
         // Byte writes replicate the byte on both lanes and enable only one.
         if (size_q == 2'd0) begin
            mem_wdata   = {wdata_q[7:0], wdata_q[7:0]};
            mem_byte_en = byte_sel_q ? 2'b10 : 2'b01;
         end else begin
            mem_wdata   = beat_q[0] ? wdata_q[31:16] : wdata_q[15:0];
            mem_byte_en = 2'b11;
         end
      end
   end

   assign cpu_enable  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign cpu_data_in = cpu_data_q;
   assign req_err     = req_err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - directed self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;

   logic        clk;
   logic        rst;
   logic        req_rd;
   logic        req_wr;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        cpu_enable;
   logic [47:0] cpu_data_in;
   logic        req_err;
   logic [30:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [1:0]  mem_byte_en;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int n_cmp;
   int n_fail;
   int strobe_clash;

   logic [15:0] mem [logic [30:0]];
   logic [30:0] rd_addrs [$];
   logic [30:0] wr_addrs [$];
   logic [1:0]  wr_bes [$];
   logic [15:0] wr_datas [$];

   cpu_mem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .req_rd      (req_rd),
      .req_wr      (req_wr),
      .req_size    (req_size),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .cpu_enable  (cpu_enable),
      .cpu_data_in (cpu_data_in),
      .req_err     (req_err),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .mem_byte_en (mem_byte_en),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      logic [15:0] cur;
      if (mem_rd) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 16'h0;
      if (mem_wr) begin
         cur = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0;
         if (mem_byte_en[0]) cur[7:0] = mem_wdata[7:0];
         if (mem_byte_en[1]) cur[15:8] = mem_wdata[15:8];
         mem[mem_addr] = cur;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd && mem_wr) strobe_clash++;
         if (mem_rd) rd_addrs.push_back(mem_addr);
         if (mem_wr) begin
            wr_addrs.push_back(mem_addr);
            wr_bes.push_back(mem_byte_en);
            wr_datas.push_back(mem_wdata);
         end
      end
   end

   task automatic clear_log();
      rd_addrs.delete();
      wr_addrs.delete();
      wr_bes.delete();
      wr_datas.delete();
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      req_rd = rd; req_wr = wr; req_size = size; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_rd = 1'b0; req_wr = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      @(negedge clk);
      while (!cpu_enable && cycles < 40) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_enable: got %0h expected 1", cpu_enable); end
      n_cmp++; if (cpu_data_in !== 48'h0) begin n_fail++; $display("FAIL reset_cpu_data_in: got %0h expected 0", cpu_data_in); end
      n_cmp++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL reset_req_err: got %0h expected 0", req_err); end
      n_cmp++; if ({mem_rd, mem_wr, mem_byte_en} !== 4'h0) begin n_fail++; $display("FAIL reset_strobes: got %0h expected 0", {mem_rd, mem_wr, mem_byte_en}); end
      n_cmp++; if ({mem_addr, mem_wdata} !== 47'h0) begin n_fail++; $display("FAIL reset_addr_wdata: got %0h expected 0", {mem_addr, mem_wdata}); end
      rst = 1'b0;
   endtask

   task automatic test_read48();
      int cyc;
      mem[31'h80] = 16'h1111; mem[31'h81] = 16'h2222; mem[31'h82] = 16'h3333;
      clear_log();
      issue(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
      wait_done(cyc);
      n_cmp++; if (cyc != 6) begin n_fail++; $display("FAIL read48_stall_cycles: got %0d expected 6", cyc); end
      n_cmp++; if (cpu_data_in !== 48'h333322221111) begin n_fail++; $display("FAIL read48_data: got %0h expected 333322221111", cpu_data_in); end
      n_cmp++; if (rd_addrs.size() != 3 || rd_addrs[0] !== 31'h80 || rd_addrs[1] !== 31'h81 || rd_addrs[2] !== 31'h82)
         begin n_fail++; $display("FAIL read48_addrs: got %0d beats expected 3 at 80,81,82", rd_addrs.size()); end
      @(negedge clk);
      n_cmp++; if (cpu_data_in !== 48'h333322221111) begin n_fail++; $display("FAIL read48_hold: got %0h expected 333322221111", cpu_data_in); end
   endtask

   task automatic test_write8();
      int cyc;
      clear_log();
      issue(1'b0, 1'b1, 2'd0, 32'h203, 32'hAB);
      wait_done(cyc);
      n_cmp++; if (cyc != 1) begin n_fail++; $display("FAIL write8_cycles: got %0d expected 1", cyc); end
      n_cmp++; if (wr_addrs.size() != 1) begin n_fail++; $display("FAIL write8_beats: got %0d expected 1", wr_addrs.size()); end
      else if (wr_addrs[0] !== 31'h101 || wr_bes[0] !== 2'b10 || wr_datas[0] !== 16'hABAB) begin
         n_fail++; $display("FAIL write8_beat: got addr %0h be %0b data %0h expected 101 10 abab", wr_addrs[0], wr_bes[0], wr_datas[0]);
      end
   endtask

   task automatic test_read_narrow();
      int cyc;
      issue(1'b1, 1'b0, 2'd1, 32'h102, 32'h0);
      wait_done(cyc);
      n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL read16_cycles: got %0d expected 2", cyc); end
      n_cmp++; if (cpu_data_in !== 48'h2222) begin n_fail++; $display("FAIL read16_data: got %0h expected 2222", cpu_data_in); end
      issue(1'b1, 1'b0, 2'd0, 32'h203, 32'h0);
      wait_done(cyc);
      n_cmp++; if (cpu_data_in !== 48'hAB) begin n_fail++; $display("FAIL read8_hi_lane: got %0h expected ab", cpu_data_in); end
      issue(1'b1, 1'b0, 2'd0, 32'h104, 32'h0);
      wait_done(cyc);
      n_cmp++; if (cpu_data_in !== 48'h33) begin n_fail++; $display("FAIL read8_lo_lane: got %0h expected 33", cpu_data_in); end
   endtask

   task automatic test_write32();
      int cyc;
      clear_log();
      issue(1'b0, 1'b1, 2'd2, 32'h300, 32'hDEADBEEF);
      wait_done(cyc);
      n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL write32_cycles: got %0d expected 2", cyc); end
      n_cmp++; if (wr_addrs.size() != 2) begin n_fail++; $display("FAIL write32_beats: got %0d expected 2", wr_addrs.size()); end
      else if (wr_addrs[0] !== 31'h180 || wr_datas[0] !== 16'hBEEF || wr_bes[0] !== 2'b11 ||
               wr_addrs[1] !== 31'h181 || wr_datas[1] !== 16'hDEAD || wr_bes[1] !== 2'b11) begin
         n_fail++; $display("FAIL write32_beat_content: got %0h/%0h %0h/%0h expected 180/beef 181/dead",
                            wr_addrs[0], wr_datas[0], wr_addrs[1], wr_datas[1]);
      end
      issue(1'b1, 1'b0, 2'd2, 32'h300, 32'h0);
      wait_done(cyc);
      n_cmp++; if (cyc != 4) begin n_fail++; $display("FAIL read32_cycles: got %0d expected 4", cyc); end
      n_cmp++; if (cpu_data_in !== 48'hDEADBEEF) begin n_fail++; $display("FAIL read32_data: got %0h expected deadbeef", cpu_data_in); end
   endtask

   task automatic test_reject_misaligned();
      clear_log();
      issue(1'b1, 1'b0, 2'd2, 32'h201, 32'h0);
      n_cmp++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %0h expected 1", req_err); end
      n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL misalign_enable: got %0h expected 1", cpu_enable); end
      n_cmp++; if (cpu_data_in !== 48'h0) begin n_fail++; $display("FAIL misalign_data: got %0h expected 0", cpu_data_in); end
      @(posedge clk); #1;
      n_cmp++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL misalign_err_pulse: got %0h expected 0", req_err); end
      n_cmp++; if (rd_addrs.size() != 0) begin n_fail++; $display("FAIL misalign_no_access: got %0d reads expected 0", rd_addrs.size()); end
   endtask

   task automatic test_reject_illegal();
      clear_log();
      issue(1'b1, 1'b1, 2'd1, 32'h10, 32'h1234);
      n_cmp++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL both_req_err: got %0h expected 1", req_err); end
      issue(1'b0, 1'b1, 2'd3, 32'h20, 32'h5678);
      n_cmp++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL write48_err: got %0h expected 1", req_err); end
      repeat (3) @(negedge clk);
      n_cmp++; if (rd_addrs.size() + wr_addrs.size() != 0) begin n_fail++; $display("FAIL illegal_no_access: got %0d accesses expected 0", rd_addrs.size() + wr_addrs.size()); end
      n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL illegal_enable: got %0h expected 1", cpu_enable); end
   endtask

   task automatic test_wrap();
      int cyc;
      mem[31'h7FFFFFFF] = 16'hBEEF; mem[31'h0] = 16'hCAFE;
      clear_log();
      issue(1'b1, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0);
      wait_done(cyc);
      n_cmp++; if (cpu_data_in !== 48'hCAFEBEEF) begin n_fail++; $display("FAIL wrap_data: got %0h expected cafebeef", cpu_data_in); end
      n_cmp++; if (rd_addrs.size() != 2 || rd_addrs[0] !== 31'h7FFFFFFF || rd_addrs[1] !== 31'h0)
         begin n_fail++; $display("FAIL wrap_addrs: got %0d beats expected 2 at 7fffffff,0", rd_addrs.size()); end
   endtask

   task automatic test_ignore_busy();
      int cyc;
      clear_log();
      issue(1'b1, 1'b0, 2'd1, 32'h100, 32'h0);
      req_wr = 1'b1; req_size = 2'd0; req_addr = 32'h10; req_wdata = 32'h55;
      wait_done(cyc);
      req_wr = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL busy_cycles: got %0d expected 2", cyc); end
      n_cmp++; if (wr_addrs.size() != 0) begin n_fail++; $display("FAIL busy_ignored: got %0d writes expected 0", wr_addrs.size()); end
      n_cmp++; if (cpu_data_in !== 48'h1111) begin n_fail++; $display("FAIL busy_data: got %0h expected 1111", cpu_data_in); end
   endtask

   task automatic test_reset_abort();
      clear_log();
      issue(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL abort_enable: got %0h expected 1", cpu_enable); end
      n_cmp++; if (cpu_data_in !== 48'h0) begin n_fail++; $display("FAIL abort_data: got %0h expected 0", cpu_data_in); end
      n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL abort_mem_rd: got %0h expected 0", mem_rd); end
      repeat (5) @(negedge clk);
      n_cmp++; if (rd_addrs.size() != 2) begin n_fail++; $display("FAIL abort_beats: got %0d reads expected 2", rd_addrs.size()); end
   endtask

   task automatic test_strobe_exclusive();
      n_cmp++; if (strobe_clash != 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d clashes expected 0", strobe_clash); end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; strobe_clash = 0;
      rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
      mem_rdata = 16'h0;
      test_reset();
      test_read48();
      test_write8();
      test_read_narrow();
      test_write32();
      test_reject_misaligned();
      test_reject_illegal();
      test_wrap();
      test_ignore_busy();
      test_reset_abort();
      test_strobe_exclusive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_rd  input  1  CPU read request (instruction fetch or load).
REQ-005 req_wr  input  1  CPU write request.
REQ-006 req_size  input  2  access size: 0=8-bit, 1=16-bit, 2=32-bit, 3=48-bit (read only).
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  write data, little-endian.
REQ-009 cpu_enable  output  1  connects to the CPU enable input; 0 stalls the CPU.
REQ-010 cpu_data_in  output  48  read data to the CPU data_in.
REQ-011 req_err  output  1  one-cycle pulse on a rejected request.
REQ-012 mem_addr  output  31  halfword address to the 16-bit synchronous SRAM.
REQ-013 mem_rd  output  1  SRAM read strobe; mem_rdata is valid the cycle after.
REQ-014 mem_wr  output  1  SRAM write strobe.
REQ-015 mem_byte_en  output  2  lane enables: bit0 = bits 7:0, bit1 = bits 15:8.
REQ-016 mem_wdata  output  16  SRAM write data.
REQ-017 mem_rdata  input  16  SRAM read data.

Function
REQ-018 States SHALL be IDLE, RD_ISSUE, RD_CAPTURE, WR_BEAT and DONE.
REQ-019 Beat count SHALL be N = 1 for size 0 or 1, 2 for size 2 and 3 for size 3; beat k uses halfword address req_addr[31:1]+k, wrapping modulo 2^31.
REQ-020 In IDLE, cpu_enable=1; a request SHALL be accepted on the edge where req_rd^req_wr=1, latching size, address and wdata.
REQ-021 Rejection: if req_rd=req_wr=1, or size≥1 with req_addr[0]=1, or req_wr with size 3, the block SHALL pulse req_err on the next cycle, make no SRAM access, set cpu_data_in=0 and stay in IDLE.
REQ-022 After acceptance, cpu_enable SHALL be 0 from the next cycle until DONE.
REQ-023 RD_ISSUE SHALL assert mem_rd for one cycle for beat k.
REQ-024 RD_CAPTURE SHALL place mem_rdata into cpu_data_in[16k+15:16k], then advance to RD_ISSUE (k+1) or to DONE.
REQ-025 Read latency: an accept edge at cycle T SHALL give DONE at T+1+2N.
REQ-026 For an 8-bit read, cpu_data_in SHALL hold the lane selected by addr[0], zero-extended; for sizes 1 and 2, unused upper bits SHALL be 0.
REQ-027 In WR_BEAT, each cycle SHALL assert mem_wr with mem_wdata = wdata[16k+15:16k] and byte_en = 2'b11; the final beat goes to DONE, so DONE is at T+1+N.
REQ-028 For an 8-bit write, byte_en SHALL be 2'b01 if addr[0]=0, else 2'b10, with the byte replicated on both lanes.
REQ-029 In DONE, cpu_enable=1 and cpu_data_in SHALL be stable for one cycle, then the state returns to IDLE; no request is accepted in DONE.
REQ-030 Request inputs seen outside IDLE SHALL be ignored.
REQ-031 mem_rd and mem_wr SHALL never both be 1; both SHALL be 0 outside RD_ISSUE and WR_BEAT.
REQ-032 cpu_data_in SHALL hold its last value until the next read completes or a rejection occurs.

Reset
REQ-033 While rst=1, the next state SHALL be IDLE, with cpu_enable=1, cpu_data_in=0, req_err=0, mem_rd=mem_wr=0, mem_byte_en=0, mem_addr=0 and mem_wdata=0.
REQ-034 Reset during any operation SHALL abort it with no further SRAM strobes, and the read data SHALL be discarded.

Verification
REQ-035 Read, size 3, addr 0x100; SRAM halfwords 0x80:0x1111, 0x81:0x2222, 0x82:0x3333 -> cpu_data_in = 0x333322221111; cpu_enable low for 6 cycles.
REQ-036 Write, size 0, addr 0x203, wdata 0xAB -> one mem_wr with mem_addr = 0x101, byte_en = 2'b10, wdata = 0xABAB; DONE at T+2.
REQ-037 Read, size 2, addr 0x201 -> req_err pulses, no mem_rd, cpu_data_in = 0, cpu_enable stays 1.
REQ-038 req_rd=req_wr=1 -> req_err pulses with no SRAM access.
REQ-039 Read, size 2, addr 0xFFFFFFFE -> beats at mem_addr 0x7FFFFFFF then 0x0 (wrap).
REQ-040 rst asserted in the cycle after the second RD_ISSUE of a size-3 read -> IDLE next cycle, no further mem_rd, cpu_data_in = 0, cpu_enable = 1.
